// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: requester/downstream bundle between two requesters and the round-robin arbiter
interface mux2_rr_arbiter_if #(parameter int WIDTH = 8);
    logic             req0;
    logic             req1;
    logic             out_ready;
    logic             gnt0;
    logic             gnt1;
    logic             select;
    logic             out_valid;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out_data;
    modport master (output req0, in0, req1, in1, out_ready, input gnt0, gnt1, select, out_valid, out_data);
    modport slave  (input req0, in0, req1, in1, out_ready, output gnt0, gnt1, select, out_valid, out_data);
endinterface

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-way round-robin arbiter onto one output; define BURST_LIMIT_EN to force
// re-arbitration after MAX_BURST transfers when the other requester is waiting.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              reset,
    mux2_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, G0, G1} state_t;
    state_t           state, nxt;
    logic             last_grant, go0, go1, hit, gnt0, gnt1, sel;
    logic [WIDTH-1:0] data;
    if (MAX_BURST < 1) begin : g_chk
        $error("MAX_BURST must be at least 1");
    end
`ifdef BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
    logic          xfer;
    logic [CW-1:0] cnt;
    assign xfer = bus.out_valid & bus.out_ready;
    // hit fires on the edge that completes the MAX_BURST-th transfer
    assign hit  = xfer && cnt == LAST;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= (hit || nxt != state) ? '0 : cnt + CW'(xfer);
`else
    assign hit = 1'b0;
`endif
    always_comb begin
        go0 = state == G0 ? bus.req0 && !(hit && bus.req1) :
              state == G1 ? bus.req0 && (!bus.req1 || hit) :
                            bus.req0 && (!bus.req1 || last_grant);
        go1 = state == G1 ? bus.req1 && !(hit && bus.req0) :
              state == G0 ? bus.req1 && (!bus.req0 || hit) :
                            bus.req1 && (!bus.req0 || !last_grant);
        nxt = go0 ? G0 : go1 ? G1 : IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= nxt;
            gnt0  <= go0;
            gnt1  <= go1;
            if (go0 || go1) begin
                sel        <= go1;
                last_grant <= go1;
            end
        end
    assign data          = sel ? bus.in1 : bus.in0;
    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.select    = sel;
    assign bus.out_data  = data;
    assign bus.out_valid = (gnt0 & bus.req0) | (gnt1 & bus.req1);
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: vector table plus multi-cycle sequences, expectations queued per cycle
module tb_mux2_rr_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        logic       r0, r1, rdy;
        logic [7:0] d0, d1;
        logic       g0, g1, sel, v;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[12];
    vec_t sb[$];

    always #5 clk = ~clk;

    mux2_rr_arbiter_if #(.WIDTH(8)) bus ();
    mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic vec_t mk(input logic r0, r1, rdy, input logic [7:0] d0, d1,
                                input logic g0, g1, sel, v, input logic [7:0] d);
        vec_t x;
        x.r0 = r0; x.r1 = r1; x.rdy = rdy; x.d0 = d0; x.d1 = d1;
        x.g0 = g0; x.g1 = g1; x.sel = sel; x.v = v; x.d = d;
        return x;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, r1, rdy, input logic [7:0] d0, d1);
        bus.req0 = r0; bus.req1 = r1; bus.out_ready = rdy; bus.in0 = d0; bus.in1 = d1;
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        drive(v.r0, v.r1, v.rdy, v.d0, v.d1);
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".gnt0"}, 8'(bus.gnt0), 8'(e.g0));
        check({tag, ".gnt1"}, 8'(bus.gnt1), 8'(e.g1));
        check({tag, ".select"}, 8'(bus.select), 8'(e.sel));
        check({tag, ".out_valid"}, 8'(bus.out_valid), 8'(e.v));
        check({tag, ".out_data"}, bus.out_data, e.d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic g0;
        tbl[0]  = mk(1, 0, 1, 8'hA5, 8'h3C, 1, 0, 0, 1, 8'hA5);
        tbl[1]  = mk(0, 0, 1, 8'hA5, 8'h3C, 0, 0, 0, 0, 8'hA5);
        tbl[2]  = mk(1, 1, 1, 8'h11, 8'h22, 0, 1, 1, 1, 8'h22);
        tbl[3]  = mk(1, 1, 1, 8'h11, 8'h22, 0, 1, 1, 1, 8'h22);
        tbl[4]  = mk(1, 0, 1, 8'h11, 8'h22, 1, 0, 0, 1, 8'h11);
        tbl[5]  = mk(0, 1, 1, 8'h33, 8'h44, 0, 1, 1, 1, 8'h44);
        tbl[6]  = mk(1, 1, 0, 8'h33, 8'h44, 0, 1, 1, 1, 8'h44);
        tbl[7]  = mk(0, 0, 1, 8'h55, 8'h66, 0, 0, 1, 0, 8'h66);
        tbl[8]  = mk(0, 1, 1, 8'h55, 8'h77, 0, 1, 1, 1, 8'h77);
        tbl[9]  = mk(0, 0, 0, 8'h55, 8'h77, 0, 0, 1, 0, 8'h77);
        tbl[10] = mk(1, 1, 1, 8'h88, 8'h99, 1, 0, 0, 1, 8'h88);
        tbl[11] = mk(0, 0, 1, 8'h88, 8'h99, 0, 0, 0, 0, 8'h88);

        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C);
        #12;
        check("reset.gnt0", 8'(bus.gnt0), 8'h0);
        check("reset.gnt1", 8'(bus.gnt1), 8'h0);
        check("reset.select", 8'(bus.select), 8'h0);
        check("reset.out_valid", 8'(bus.out_valid), 8'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);

        for (int i = 0; i < 12; i++) step($sformatf("tbl%0d", i), tbl[i]);

        // tie after reset goes to requester 0, then a clean handover with no idle cycle
        do_reset();
        step("tie0", mk(1, 1, 1, 8'hC1, 8'hD2, 1, 0, 0, 1, 8'hC1));
        step("handover", mk(0, 1, 1, 8'hC1, 8'hD2, 0, 1, 1, 1, 8'hD2));
        for (int i = 0; i < 5; i++)
            step($sformatf("stall%0d", i), mk(1, 1, 0, 8'hC1, 8'hD2, 0, 1, 1, 1, 8'hD2));

        // both held with ready: burst limit alternates every 4 transfers, otherwise G0 sticks
        do_reset();
        for (int k = 0; k < 12; k++) begin
`ifdef BURST_LIMIT_EN
            g0 = ((k / 4) % 2) == 0;
`else
            g0 = 1'b1;
`endif
            step($sformatf("burst%0d", k), mk(1, 1, 1, 8'hAA, 8'hBB, g0, !g0, !g0, 1, g0 ? 8'hAA : 8'hBB));
        end

        // lone requester keeps its grant regardless of the limit
        do_reset();
        for (int k = 0; k < 10; k++)
            step($sformatf("solo%0d", k), mk(1, 0, 1, 8'h5A, 8'hBB, 1, 0, 0, 1, 8'h5A));

        // reset between edges must drop the grant immediately
        do_reset();
        step("pre_rst", mk(0, 1, 1, 8'h01, 8'h02, 0, 1, 1, 1, 8'h02));
        #3;
        reset = 1'b1;
        #1;
        check("midrst.gnt1", 8'(bus.gnt1), 8'h0);
        check("midrst.gnt0", 8'(bus.gnt0), 8'h0);
        check("midrst.out_valid", 8'(bus.out_valid), 8'h0);
        check("midrst.select", 8'(bus.select), 8'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post_rst", mk(1, 1, 1, 8'h01, 8'h02, 1, 0, 0, 1, 8'h01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
